// File: rtl/cp0_unit.sv
// rtl/cp0_unit.sv - MIPS-style CP0: status/cause/EPC, exception and interrupt entry, ERET
// Optional Count/Compare timer is built only when CP0_TIMER_EN is defined.
module cp0_unit #(
    parameter int          NUM_HWINT = 6,
    parameter logic [31:0] RESET_EPC = 32'h0000_3000,
    parameter logic [31:0] PRID_VAL  = 32'hBAAD_FACE
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          pc,
    input  logic                 bd_in,
    input  logic [4:0]           reg_id,
    input  logic [31:0]          wdata,
    input  logic                 mtc0_en,
    input  logic                 mfc0_en,
    input  logic                 eret_en,
    input  logic                 exc_valid,
    input  logic [4:0]           exc_code,
    input  logic [31:0]          badvaddr_in,
    input  logic [NUM_HWINT-1:0] hwint,
    output logic [31:0]          rdata,
    output logic [1:0]           kctrl,
    output logic [31:0]          epc,
    output logic                 timer_irq
);

    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_SR       = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;
    localparam logic [4:0] REG_PRID     = 5'd15;

    logic [NUM_HWINT-1:0] im_q, im_d;
    logic [NUM_HWINT-1:0] ip_q, ip_d;
    logic                 exl_q, exl_d;
    logic                 ie_q, ie_d;
    logic                 bd_q, bd_d;
    logic [4:0]           exccode_q, exccode_d;
    logic [31:0]          epc_q, epc_d;
    logic [31:0]          badvaddr_q, badvaddr_d;

    logic                 timer_line;
    logic [31:0]          count_rd;
    logic [31:0]          compare_rd;

    logic [NUM_HWINT-1:0] irq_vec;
    logic                 int_req;
    logic                 take_exc;
    logic                 take_eret;
    logic                 take_int;
    logic                 entry;
    logic                 do_mtc0;
    logic [31:0]          epc_src;
    logic [5:0]           im_ext;
    logic [5:0]           ip_ext;

    // The timer shares the highest hardware line, as on the classic R4000 layout.
    always_comb begin
        irq_vec                = hwint;
        irq_vec[NUM_HWINT-1]   = hwint[NUM_HWINT-1] | timer_line;
    end

    assign int_req   = (|(im_q & irq_vec)) & ie_q & ~exl_q;
    assign take_exc  = exc_valid;
    assign take_eret = eret_en & ~exc_valid;
    assign take_int  = int_req & ~exc_valid & ~eret_en;
    assign entry     = take_exc | take_int;
    assign do_mtc0   = mtc0_en & ~exc_valid & ~eret_en & ~int_req;
    assign epc_src   = bd_in ? (pc - 32'd4) : pc;

    always_comb begin
        kctrl = 2'b00;
        if (entry) begin
            kctrl = 2'b01;
        end else if (take_eret) begin
            kctrl = 2'b10;
        end
    end

    always_comb begin
        im_d       = im_q;
        ip_d       = irq_vec;
        exl_d      = exl_q;
        ie_d       = ie_q;
        bd_d       = bd_q;
        exccode_d  = exccode_q;
        epc_d      = epc_q;
        badvaddr_d = badvaddr_q;
        if (entry) begin
            exl_d     = 1'b1;
            bd_d      = bd_in;
            epc_d     = {epc_src[31:2], 2'b00};
            exccode_d = take_exc ? exc_code : 5'd0;
            if (take_exc && (exc_code == 5'd4 || exc_code == 5'd5)) begin
                badvaddr_d = badvaddr_in;
            end
        end else if (take_eret) begin
            exl_d     = 1'b0;
            exccode_d = 5'd0;
            bd_d      = 1'b0;
        end else if (do_mtc0) begin
            case (reg_id)
                REG_SR: begin
                    im_d  = wdata[10 +: NUM_HWINT];
                    exl_d = wdata[1];
                    ie_d  = wdata[0];
                end
                REG_EPC: epc_d = {wdata[31:2], 2'b00};
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            im_q       <= '1;
            ip_q       <= '0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b1;
            bd_q       <= 1'b0;
            exccode_q  <= 5'd0;
            epc_q      <= RESET_EPC;
            badvaddr_q <= 32'd0;
        end else begin
            im_q       <= im_d;
            ip_q       <= ip_d;
            exl_q      <= exl_d;
            ie_q       <= ie_d;
            bd_q       <= bd_d;
            exccode_q  <= exccode_d;
            epc_q      <= epc_d;
            badvaddr_q <= badvaddr_d;
        end
    end

`ifdef CP0_TIMER_EN
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        timer_q, timer_d;

    // A Compare write clears the pending timer even if Count matches this cycle.
    always_comb begin
        count_d   = count_q + 32'd1;
        compare_d = compare_q;
        timer_d   = timer_q;
        if (do_mtc0 && reg_id == REG_COUNT) begin
            count_d = wdata;
        end
        if (do_mtc0 && reg_id == REG_COMPARE) begin
            compare_d = wdata;
            timer_d   = 1'b0;
        end else if (count_q == compare_q) begin
            timer_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q   <= 32'd0;
            compare_q <= 32'hFFFF_FFFF;
            timer_q   <= 1'b0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            timer_q   <= timer_d;
        end
    end

    assign timer_line = timer_q;
    assign count_rd   = count_q;
    assign compare_rd = compare_q;
`else
    assign timer_line = 1'b0;
    assign count_rd   = 32'd0;
    assign compare_rd = 32'd0;
`endif

    always_comb begin
        im_ext                = '0;
        ip_ext                = '0;
        im_ext[NUM_HWINT-1:0] = im_q;
        ip_ext[NUM_HWINT-1:0] = ip_q;
    end

    always_comb begin
        rdata = 32'd0;
        if (mfc0_en) begin
            case (reg_id)
                REG_SR:       rdata = {16'd0, im_ext, 8'd0, exl_q, ie_q};
                REG_CAUSE:    rdata = {bd_q, 15'd0, ip_ext, 3'd0, exccode_q, 2'b00};
                REG_EPC:      rdata = epc_q;
                REG_PRID:     rdata = PRID_VAL;
                REG_BADVADDR: rdata = badvaddr_q;
                REG_COUNT:    rdata = count_rd;
                REG_COMPARE:  rdata = compare_rd;
                default:      rdata = 32'd0;
            endcase
        end
    end

    assign epc       = epc_q;
    assign timer_irq = timer_line;

endmodule

// File: tb/tb_cp0_unit.sv
// tb/tb_cp0_unit.sv - directed self-checking bench for cp0_unit
`timescale 1ns/1ps
module tb_cp0_unit;

    logic        clk;
    logic        reset;
    logic [31:0] pc;
    logic        bd_in;
    logic [4:0]  reg_id;
    logic [31:0] wdata;
    logic        mtc0_en, mfc0_en, eret_en;
    logic        exc_valid;
    logic [4:0]  exc_code;
    logic [31:0] badvaddr_in;
    logic [5:0]  hwint;
    logic [31:0] rdata;
    logic [1:0]  kctrl;
    logic [31:0] epc;
    logic        timer_irq;

    int checks   = 0;
    int failures = 0;

    cp0_unit dut (
        .clk(clk), .reset(reset), .pc(pc), .bd_in(bd_in), .reg_id(reg_id),
        .wdata(wdata), .mtc0_en(mtc0_en), .mfc0_en(mfc0_en), .eret_en(eret_en),
        .exc_valid(exc_valid), .exc_code(exc_code), .badvaddr_in(badvaddr_in),
        .hwint(hwint), .rdata(rdata), .kctrl(kctrl), .epc(epc), .timer_irq(timer_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #0.2;
    endtask

    task automatic chk_reg(input string tag, input logic [4:0] r, input logic [31:0] exp);
        reg_id  = r;
        mfc0_en = 1'b1;
        settle();
        check(tag, rdata, exp);
        mfc0_en = 1'b0;
        settle();
    endtask

    task automatic mtc0(input logic [4:0] r, input logic [31:0] d);
        reg_id  = r;
        wdata   = d;
        mtc0_en = 1'b1;
        step();
        mtc0_en = 1'b0;
    endtask

    task automatic eret_clear();
        hwint   = 6'd0;
        eret_en = 1'b1;
        step();
        eret_en = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; pc = 32'h7000; bd_in = 1'b1; reg_id = 5'd12; wdata = 32'h0;
        mtc0_en = 1'b1; mfc0_en = 1'b0; eret_en = 1'b0; exc_valid = 1'b1;
        exc_code = 5'd5; badvaddr_in = 32'hABCD; hwint = 6'h3F;
        step();
        step();
        mtc0_en = 1'b0; exc_valid = 1'b0; hwint = 6'd0; bd_in = 1'b0;

        reg_id = 5'd12; settle();
        check("rst_rdata_idle", rdata, 32'h0);
        chk_reg("rst_sr", 5'd12, 32'h0000_FC01);
        chk_reg("rst_cause", 5'd13, 32'h0);
        chk_reg("rst_epc_reg", 5'd14, 32'h0000_3000);
        check("rst_epc_out", epc, 32'h0000_3000);
        chk_reg("rst_badvaddr", 5'd8, 32'h0);
        chk_reg("rst_prid", 5'd15, 32'hBAAD_FACE);
        chk_reg("unknown_reg", 5'd20, 32'h0);
        check("rst_timer", {31'd0, timer_irq}, 32'd0);
`ifdef CP0_TIMER_EN
        chk_reg("rst_count", 5'd9, 32'h0);
        chk_reg("rst_compare", 5'd11, 32'hFFFF_FFFF);
`endif
        reset = 1'b0;
        settle();
        check("rst_kctrl", {30'd0, kctrl}, 32'd0);

        // interrupt entry on line 2
        hwint = 6'b000100; pc = 32'h3010; bd_in = 1'b0;
        settle();
        check("int_kctrl", {30'd0, kctrl}, 32'd1);
        step();
        check("int_epc", epc, 32'h3010);
        chk_reg("int_sr", 5'd12, 32'h0000_FC03);
        chk_reg("int_cause", 5'd13, 32'h0000_1000);
        check("int_exl_kctrl", {30'd0, kctrl}, 32'd0);

        // ERET with line still active: return, then re-entry next cycle
        eret_en = 1'b1; pc = 32'h3040;
        settle();
        check("eret_kctrl", {30'd0, kctrl}, 32'd2);
        step();
        eret_en = 1'b0;
        chk_reg("eret_sr", 5'd12, 32'h0000_FC01);
        check("reint_kctrl", {30'd0, kctrl}, 32'd1);
        step();
        check("reint_epc", epc, 32'h3040);
        eret_clear();

        // address-error exception in a delay slot beats a pending interrupt
        exc_valid = 1'b1; exc_code = 5'd4; badvaddr_in = 32'h1003; bd_in = 1'b1;
        pc = 32'h3024; hwint = 6'b000100;
        settle();
        check("exc_kctrl", {30'd0, kctrl}, 32'd1);
        step();
        exc_valid = 1'b0; bd_in = 1'b0;
        check("exc_epc", epc, 32'h3020);
        chk_reg("exc_cause", 5'd13, 32'h8000_1010);
        chk_reg("exc_badvaddr", 5'd8, 32'h1003);
        eret_clear();
        chk_reg("eret_cause", 5'd13, 32'h0);
        check("eret_epc_kept", epc, 32'h3020);

        // syscall: BadVAddr untouched
        exc_valid = 1'b1; exc_code = 5'd8; badvaddr_in = 32'hDEAD_BEEF; pc = 32'h3100;
        step();
        exc_valid = 1'b0;
        chk_reg("sys_badvaddr", 5'd8, 32'h1003);
        chk_reg("sys_cause", 5'd13, 32'h0000_0020);
        check("sys_epc", epc, 32'h3100);
        eret_clear();

        // IM mask only line 0
        mtc0(5'd12, 32'h0000_0401);
        chk_reg("mtc0_sr", 5'd12, 32'h0000_0401);
        hwint = 6'b000010;
        settle();
        check("masked_kctrl", {30'd0, kctrl}, 32'd0);
        step();
        chk_reg("masked_sr", 5'd12, 32'h0000_0401);
        hwint = 6'b000001; pc = 32'h3200;
        settle();
        check("unmasked_kctrl", {30'd0, kctrl}, 32'd1);
        step();
        chk_reg("unmasked_sr", 5'd12, 32'h0000_0403);
        check("unmasked_epc", epc, 32'h3200);
        eret_clear();

        // entry suppresses a same-cycle MTC0
        hwint = 6'b000001;
        mtc0(5'd12, 32'h0);
        hwint = 6'd0;
        chk_reg("suppress_sr", 5'd12, 32'h0000_0403);
        eret_clear();

        mtc0(5'd14, 32'h0000_1237);
        check("mtc0_epc", epc, 32'h0000_1234);
        mtc0(5'd13, 32'hFFFF_FFFF);
        chk_reg("ro_cause", 5'd13, 32'h0);
        mtc0(5'd15, 32'h0);
        chk_reg("ro_prid", 5'd15, 32'hBAAD_FACE);
        mtc0(5'd8, 32'h0);
        chk_reg("ro_badvaddr", 5'd8, 32'h1003);

        mtc0(5'd12, 32'h0);
`ifdef CP0_TIMER_EN
        mtc0(5'd9, 32'hFFFF_FFFE);
        mtc0(5'd11, 32'h0000_0001);
        chk_reg("cnt_ffff", 5'd9, 32'hFFFF_FFFF);
        chk_reg("cmp_val", 5'd11, 32'h1);
        step();
        chk_reg("cnt_wrap", 5'd9, 32'h0);
        step();
        check("tmr_not_yet", {31'd0, timer_irq}, 32'd0);
        step();
        check("tmr_rise", {31'd0, timer_irq}, 32'd1);
        step();
        check("tmr_sticky", {31'd0, timer_irq}, 32'd1);
        chk_reg("tmr_ip15", 5'd13, 32'h0000_8000);
        mtc0(5'd11, 32'h0000_1000);
        check("tmr_clear", {31'd0, timer_irq}, 32'd0);
        mtc0(5'd9, 32'h20);
        mtc0(5'd11, 32'h21);
        mtc0(5'd11, 32'h100);
        check("tmr_clear_wins", {31'd0, timer_irq}, 32'd0);
`else
        mtc0(5'd9, 32'h55);
        chk_reg("no_count", 5'd9, 32'h0);
        mtc0(5'd11, 32'h55);
        chk_reg("no_compare", 5'd11, 32'h0);
        check("no_timer", {31'd0, timer_irq}, 32'd0);
`endif

        // reset wins over a same-cycle exception
        reset = 1'b1; exc_valid = 1'b1; exc_code = 5'd5; badvaddr_in = 32'hABC;
        pc = 32'h7777; hwint = 6'h3F;
        step();
        reset = 1'b0; exc_valid = 1'b0; hwint = 6'd0;
        check("rst2_epc", epc, 32'h0000_3000);
        chk_reg("rst2_sr", 5'd12, 32'h0000_FC01);
        chk_reg("rst2_cause", 5'd13, 32'h0);
        chk_reg("rst2_badvaddr", 5'd8, 32'h0);
        check("rst2_timer", {31'd0, timer_irq}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cp0_unit.md
CP0_UNIT -- requirements
Module: cp0_unit

Interface
REQ-001 SHALL have parameter NUM_HWINT, default 6, meaning hardware interrupt line count (legal range 1..6).
REQ-002 SHALL have parameter RESET_EPC, default 32'h0000_3000, meaning EPC value after reset.
REQ-003 SHALL have parameter PRID_VAL, default 32'hBAAD_FACE, meaning read-only PRId contents.
REQ-004 SHALL have port clk  in  1  clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  in  1  reset, synchronous, active-high.
REQ-006 SHALL have ports pc  in  32  PC of the instruction in MEM; bd_in  in  1  that instruction is in a delay slot.
REQ-007 SHALL have ports reg_id  in  5  CP0 register number; wdata  in  32  MTC0 data; mtc0_en, mfc0_en, eret_en  in  1 each.
REQ-008 SHALL have ports exc_valid  in  1; exc_code  in  5; badvaddr_in  in  32  faulting address.
REQ-009 SHALL have port hwint  in  NUM_HWINT  level-sensitive device interrupts.
REQ-010 SHALL have ports rdata  out  32; kctrl  out  2; epc  out  32; timer_irq  out  1.

Function
REQ-011 SHALL implement SR(12)={16'b0,IM[15:10],8'b0,EXL,IE}; Cause(13)={BD,15'b0,IP[15:10],3'b0,ExcCode[4:0],2'b0}; EPC(14); PRId(15); BadVAddr(8); Count(9); Compare(11); unused IM/IP bits above NUM_HWINT read 0.
REQ-012 SHALL drive rdata combinationally: selected register when mfc0_en, else 0; unknown reg_id reads 0.
REQ-013 SHALL form effective line vector irq_vec = hwint, with timer_irq ORed into bit NUM_HWINT-1.
REQ-014 SHALL compute int_req = |(IM & irq_vec) & IE & !EXL, combinationally.
REQ-015 SHALL decide priority per cycle: exc_valid > eret_en > int_req > mtc0_en; an entry (exception or interrupt) suppresses the same-cycle MTC0 write.
REQ-016 SHALL drive kctrl combinationally: 2'b01 on entry, 2'b10 on eret_en without exc_valid, else 2'b00.
REQ-017 SHALL on entry set EXL=1, BD=bd_in, EPC={(bd_in ? pc-4 : pc)[31:2],2'b00}; ExcCode=exc_code for exception, 0 for interrupt.
REQ-018 SHALL load BadVAddr=badvaddr_in only on exception entry with exc_code 4 or 5.
REQ-019 SHALL on ERET set EXL=0, ExcCode=0, BD=0; EPC unchanged.
REQ-020 SHALL update IP every cycle with irq_vec, one-cycle latency.
REQ-021 SHALL on MTC0 write SR (IM, EXL, IE from wdata[15:10],[1],[0]), EPC (wdata with [1:0] forced 0), Count, or Compare; writes to Cause, PRId, BadVAddr ignored.
REQ-022 SHALL increment Count by 1 every cycle, wrapping 32'hFFFF_FFFF->0; an MTC0 Count loads wdata instead of incrementing that cycle.
REQ-023 SHALL set timer_irq (sticky) on the edge after a cycle where Count==Compare; MTC0 Compare clears it, and clear wins over a same-cycle match.
REQ-024 SHALL drive epc output directly from the EPC register.

Reset
REQ-025 SHALL on reset set IM=all ones, EXL=0, IE=1, IP=0, ExcCode=0, BD=0, EPC=RESET_EPC, BadVAddr=0, Count=0, Compare=32'hFFFF_FFFF, timer_irq=0; reset overrides every same-cycle event.
REQ-026 SHALL hold combinational outputs reset-consistent: rdata=0 unless mfc0_en, kctrl per REQ-016 from reset register values.

Configuration
REQ-027 SHALL, with CP0_TIMER_EN defined, implement Count, Compare and timer_irq per REQ-022/023.
REQ-028 SHALL, without CP0_TIMER_EN, omit Count/Compare storage, read regs 9/11 as 0, ignore their writes, tie timer_irq=0.

Verification
REQ-029 SHALL cover: hwint=6'b000100, IE=1, EXL=0, pc=32'h3010, bd_in=0 -> kctrl=01, next cycle EPC=32'h3010, EXL=1, ExcCode=0, Cause IP bit 12 set.
REQ-030 SHALL cover: exc_valid=1, exc_code=4, badvaddr_in=32'h1003, bd_in=1, pc=32'h3024, same-cycle hwint active -> exception taken, EPC=32'h3020, BD=1, BadVAddr=32'h1003, ExcCode=4.
REQ-031 SHALL cover: EXL=1, eret_en=1 with hwint active -> kctrl=10, EXL=0 next cycle; interrupt taken the following cycle.
REQ-032 SHALL cover: MTC0 SR wdata=32'h0000_0401, hwint=6'b000010 -> no entry; hwint=6'b000001 -> entry.
REQ-033 SHALL cover (CP0_TIMER_EN): MTC0 Count=32'hFFFF_FFFE, Compare=32'h0000_0001 -> Count wraps to 0, timer_irq rises 3 cycles later, MTC0 Compare clears it.
REQ-034 SHALL cover: reset asserted during a cycle with exc_valid=1 -> all registers at REQ-025 values, EPC=32'h0000_3000.
